dca_matrix_lsu_rdata_aligner: RTL

- Load-side counterpart of the matrix LSU write-data path.
- Takes one read-transaction descriptor, collects the AXI R beats of that burst into a staging buffer, and right-shifts the buffer by the bit-address offset. It then presents one aligned memory row, plus the descriptor, to the LSU row consumer.
- Sits between the LSU AXI read channel and the matrix row buffer.

---
 rtl/dca_matrix_lsu_rdata_aligner_pkg.sv | 28 ++
 rtl/dca_rdata_beat_packer.sv | 57 +++++
 rtl/dca_matrix_lsu_rdata_aligner.sv | 120 ++++++++++++
 3 files changed

// File: rtl/dca_matrix_lsu_rdata_aligner_pkg.sv
// Shared definitions for the matrix LSU read-data aligner: descriptor packing,
// offset gating helper and the FSM state encoding.
package dca_matrix_lsu_rdata_aligner_pkg;

  localparam int BW_AXI_ALEN = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_e;

  // Descriptor is {flag1, flag0, alen, bitaddr}.
  function automatic int txn_info_width(input int bw_bitaddr);
    return 2 + BW_AXI_ALEN + bw_bitaddr;
  endfunction

  // Bit mask applied to the bit-address offset: [2:0] sub-byte, [bw_offset-1:3] multi-byte.
  function automatic int offset_mask(input int bw_offset, input bit multibyte, input bit subbyte);
    int m;
    m = 0;
    for (int i = 0; i < bw_offset; i++) begin
      if ((i < 3 && subbyte) || (i >= 3 && multibyte)) m = m | (1 << i);
    end
    return m;
  endfunction

endpackage

// File: rtl/dca_rdata_beat_packer.sv
// Staging buffer for the R beats of one burst: beat counter, placement of each
// beat at its slot, and discard of beats beyond the buffer depth.
module dca_rdata_beat_packer
  import dca_matrix_lsu_rdata_aligner_pkg::*;
#(
  parameter int BW_AXI_DATA = 32,
  parameter int BW_ROW      = 64
) (
  input  logic                          clk,
  input  logic                          rstnn,
  input  logic                          i_clear,
  input  logic                          i_beat_hs,
  input  logic [BW_AXI_DATA-1:0]        i_rdata,
  input  logic [BW_AXI_ALEN-1:0]        i_alen,
  output logic                          o_last_beat,
  output logic [BW_ROW+BW_AXI_DATA-1:0] o_stage_merged
);

  localparam int BW_STAGE  = BW_ROW + BW_AXI_DATA;
  localparam int MAX_BEATS = BW_STAGE / BW_AXI_DATA;

  logic [BW_STAGE-1:0]    r_stage;
  logic [BW_AXI_ALEN-1:0] r_beat_cnt;

  assign o_last_beat = (r_beat_cnt == i_alen);

  // Stage contents including the beat being accepted this cycle, so the final
  // beat can be aligned without an extra cycle.
  // NOTE: every always_comb output gets its default first; a path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    o_stage_merged = r_stage;
    for (int b = 0; b < MAX_BEATS; b++) begin
      if (i_beat_hs && (r_beat_cnt == BW_AXI_ALEN'(b))) begin
        o_stage_merged[b*BW_AXI_DATA +: BW_AXI_DATA] = i_rdata;
      end
    end
  end

  // NOTE: the stage is a plain register bank, not a RAM, so it is reset and
  // cleared per burst; unwritten slots must read as zero for the shifter.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_stage    <= '0;
      r_beat_cnt <= '0;
    end else if (i_clear) begin
      r_stage    <= '0;
      r_beat_cnt <= '0;
    end else if (i_beat_hs) begin
      r_stage <= o_stage_merged;
      if (!o_last_beat) r_beat_cnt <= r_beat_cnt + BW_AXI_ALEN'(1);
    end
  end

endmodule

// File: rtl/dca_matrix_lsu_rdata_aligner.sv
// Matrix LSU read-data aligner: collects one AXI R burst and right-shifts it by
// the bit-address offset into one memory row. Optional macro:
// DCA_MATRIX_LSU_RDATA_ALIGNER_RLAST_CHECK_EN adds the sticky err_rlast output.
module dca_matrix_lsu_rdata_aligner
  import dca_matrix_lsu_rdata_aligner_pkg::*;
#(
  parameter int BW_AXI_DATA       = 32,
  parameter int BW_ROW            = 64,
  parameter int BW_BITADDR        = 35,
  parameter int SUPPORT_MULTIBYTE = 1,
  parameter int SUPPORT_SUBBYTE   = 1,
  localparam int BW_TXN_INFO      = txn_info_width(BW_BITADDR)
) (
  input  logic                   clk,
  input  logic                   rstnn,
  input  logic                   txn_valid,
  output logic                   txn_ready,
  input  logic [BW_TXN_INFO-1:0] txn_info,
  input  logic                   rvalid,
  output logic                   rready,
  input  logic [BW_AXI_DATA-1:0] rdata,
  input  logic                   rlast,
`ifdef DCA_MATRIX_LSU_RDATA_ALIGNER_RLAST_CHECK_EN
  output logic                   err_rlast,
`endif
  output logic                   row_valid,
  input  logic                   row_ready,
  output logic [BW_ROW-1:0]      row_data,
  output logic [BW_TXN_INFO-1:0] row_txn_info
);

  localparam int BW_OFFSET = $clog2(BW_AXI_DATA);
  localparam int BW_STAGE  = BW_ROW + BW_AXI_DATA;
  localparam logic [BW_OFFSET-1:0] OFFSET_MASK =
    BW_OFFSET'(offset_mask(BW_OFFSET, SUPPORT_MULTIBYTE != 0, SUPPORT_SUBBYTE != 0));

  state_e                 r_state, w_state_next;
  logic [BW_TXN_INFO-1:0] r_txn_info;
  logic [BW_ROW-1:0]      r_row_data;
  logic                   w_txn_hs, w_r_hs, w_row_hs, w_last_beat;
  logic [BW_STAGE-1:0]    w_stage_merged, w_shifted;
  logic [BW_OFFSET-1:0]   w_offset;
  logic                   w_unused_bits;

  assign w_txn_hs = txn_valid & txn_ready;
  assign w_r_hs   = rvalid & rready;
  assign w_row_hs = row_valid & row_ready;

  dca_rdata_beat_packer #(
    .BW_AXI_DATA (BW_AXI_DATA),
    .BW_ROW      (BW_ROW)
  ) u_packer (
    .clk            (clk),
    .rstnn          (rstnn),
    .i_clear        (w_txn_hs),
    .i_beat_hs      (w_r_hs),
    .i_rdata        (rdata),
    .i_alen         (r_txn_info[BW_BITADDR +: BW_AXI_ALEN]),
    .o_last_beat    (w_last_beat),
    .o_stage_merged (w_stage_merged)
  );

  assign w_offset  = r_txn_info[BW_OFFSET-1:0] & OFFSET_MASK;
  assign w_shifted = w_stage_merged >> w_offset;

  always_comb begin
    w_state_next = r_state;
    txn_ready    = 1'b0;
    rready       = 1'b0;
    row_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        txn_ready = 1'b1;
        if (w_txn_hs) w_state_next = ST_COLLECT;
      end
      ST_COLLECT: begin
        rready = 1'b1;
        if (w_r_hs && w_last_beat) w_state_next = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        row_valid = 1'b1;
        txn_ready = row_ready;
        // A waiting descriptor is taken together with the row: no idle bubble.
        if (w_row_hs) w_state_next = txn_valid ? ST_COLLECT : ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_state    <= ST_IDLE;
      r_txn_info <= '0;
      r_row_data <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_txn_hs) r_txn_info <= txn_info;
      if (w_r_hs && w_last_beat) r_row_data <= w_shifted[BW_ROW-1:0];
    end
  end

  assign row_data     = r_row_data;
  assign row_txn_info = r_txn_info;

`ifdef DCA_MATRIX_LSU_RDATA_ALIGNER_RLAST_CHECK_EN
  logic r_err_rlast;

  // rlast must coincide exactly with the alen-defined final beat.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) r_err_rlast <= 1'b0;
    else if (w_r_hs && (rlast != w_last_beat)) r_err_rlast <= 1'b1;
  end

  assign err_rlast     = r_err_rlast;
  assign w_unused_bits = &{1'b0, w_shifted[BW_STAGE-1:BW_ROW]};
`else
  assign w_unused_bits = &{1'b0, w_shifted[BW_STAGE-1:BW_ROW], rlast};
`endif

endmodule
